// File: rtl/memory_stage.sv
// MEM stage of the TP4 pipeline: word-addressed data RAM with a fixed
// multi-cycle access latency, branch resolution, forwarding taps toward
// the execute stage and the MEM/WB pipeline latch.
module memory_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        in_wb,
  input  logic [2:0]        in_mem,
  input  logic [DATA_W-1:0] in_pc_jump,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_alu_zero,
  input  logic [DATA_W-1:0] in_reg_b,
  input  logic [4:0]        in_wreg,
  output logic [4:0]        fwd_rd,
  output logic              fwd_regF_wr,
  output logic [DATA_W-1:0] fwd_alu_result,
  output logic              out_pc_src,
  output logic [DATA_W-1:0] out_pc_jump,
  output logic              out_stall,
  output logic              out_misalign,
  output logic [1:0]        out_wb,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [4:0]        out_wreg
);

  typedef enum logic {IDLE, WAIT} state_t;

  // Count value at which the waiting access completes (MEM_LAT-1 cycles of stall).
  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t            state;
  state_t            stateNext;
  logic [3:0]        waitCnt;
  logic [3:0]        waitCntNext;
  logic              access;
  logic              isWrite;
  logic              isRead;
  logic              complete;
  logic              latchIn;
  logic [ADDR_W-1:0] wordAddr;
  logic [DATA_W-1:0] readWord;
  logic              unusedAddrBits;

  // Zero at time 0 only; never cleared by reset.
  logic [DATA_W-1:0] ram [2**ADDR_W] = '{default: '0};

  // Forwarding taps and branch resolution are pure wiring, independent of the FSM.
  assign fwd_rd         = in_wreg;
  assign fwd_regF_wr    = in_wb[1];
  assign fwd_alu_result = in_alu_result;
  assign out_pc_src     = in_mem[2] & in_alu_zero;
  assign out_pc_jump    = in_pc_jump;

  // Both memread and memwrite set is treated as a write.
  assign access   = in_mem[1] | in_mem[0];
  assign isWrite  = in_mem[0];
  assign isRead   = in_mem[1] & ~in_mem[0];
  assign wordAddr = in_alu_result[ADDR_W+1:2];
  assign readWord = ram[wordAddr];

  // Address bits above the RAM depth are ignored so accesses wrap.
  assign unusedAddrBits = ^in_alu_result[DATA_W-1:ADDR_W+2];

  // Next-state, stall and completion decode for the access FSM.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    out_stall   = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (MEM_LAT == 1) begin
            complete = 1'b1;
          end else begin
            out_stall   = 1'b1;
            stateNext   = WAIT;
            waitCntNext = 4'd1;
          end
        end
      end
      WAIT: begin
        if (waitCnt == LAST_CNT) begin
          complete    = 1'b1;
          stateNext   = IDLE;
          waitCntNext = 4'd0;
        end else begin
          out_stall   = 1'b1;
          waitCntNext = waitCnt + 4'd1;
        end
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = 4'd0;
      end
    endcase
    if (!rst) begin
      out_stall = 1'b0;
    end
  end

  // MEM/WB takes new inputs on completion or on a non-memory instruction; otherwise a bubble.
  assign latchIn = complete | ((state == IDLE) & ~access);

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // RAM write port: commits once, on the completion edge, and never while in reset.
  always_ff @(posedge clk) begin
    if (rst && complete && isWrite) begin
      ram[wordAddr] <= in_reg_b;
    end
  end

  // MEM/WB latch and the one-cycle misalignment flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_wb         <= '0;
      out_read_data  <= '0;
      out_alu_result <= '0;
      out_wreg       <= '0;
      out_misalign   <= 1'b0;
    end else begin
      out_misalign <= (state == IDLE) && access && (in_alu_result[1:0] != 2'b00);
      if (latchIn) begin
        out_wb         <= in_wb;
        out_alu_result <= in_alu_result;
        out_wreg       <= in_wreg;
        out_read_data  <= (complete && isRead) ? readWord : '0;
      end else begin
        out_wb <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with MEM_LAT=2, ADDR_W=10: one table row
// per clock cycle plus a hand-written reset-during-wait sequence.
module tb_memory_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        in_wb;
  logic [2:0]        in_mem;
  logic [DATA_W-1:0] in_pc_jump;
  logic [DATA_W-1:0] in_alu_result;
  logic              in_alu_zero;
  logic [DATA_W-1:0] in_reg_b;
  logic [4:0]        in_wreg;
  logic [4:0]        fwd_rd;
  logic              fwd_regF_wr;
  logic [DATA_W-1:0] fwd_alu_result;
  logic              out_pc_src;
  logic [DATA_W-1:0] out_pc_jump;
  logic              out_stall;
  logic              out_misalign;
  logic [1:0]        out_wb;
  logic [DATA_W-1:0] out_read_data;
  logic [DATA_W-1:0] out_alu_result;
  logic [4:0]        out_wreg;

  int nApplied = 0;
  int nMiscompare = 0;

  memory_stage #(.DATA_W(DATA_W), .ADDR_W(10), .MEM_LAT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_wb          (in_wb),
    .in_mem         (in_mem),
    .in_pc_jump     (in_pc_jump),
    .in_alu_result  (in_alu_result),
    .in_alu_zero    (in_alu_zero),
    .in_reg_b       (in_reg_b),
    .in_wreg        (in_wreg),
    .fwd_rd         (fwd_rd),
    .fwd_regF_wr    (fwd_regF_wr),
    .fwd_alu_result (fwd_alu_result),
    .out_pc_src     (out_pc_src),
    .out_pc_jump    (out_pc_jump),
    .out_stall      (out_stall),
    .out_misalign   (out_misalign),
    .out_wb         (out_wb),
    .out_read_data  (out_read_data),
    .out_alu_result (out_alu_result),
    .out_wreg       (out_wreg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] regB;
    logic [4:0]  wreg;
    logic [31:0] pcJump;
    logic        expStall;
    logic        expPcSrc;
    logic [1:0]  expWb;
    logic [31:0] expAlu;
    logic [4:0]  expWreg;
    logic [31:0] expRd;
    logic        expMis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompare++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] alu,
                       input logic zero, input logic [31:0] regB, input logic [4:0] wreg,
                       input logic [31:0] pcJump);
    in_wb = wb; in_mem = mem; in_alu_result = alu; in_alu_zero = zero;
    in_reg_b = regB; in_wreg = wreg; in_pc_jump = pcJump;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".wb"},   32'(out_wb), 32'd0);
    check({tag, ".rd"},   out_read_data, 32'd0);
    check({tag, ".alu"},  out_alu_result, 32'd0);
    check({tag, ".wreg"}, 32'(out_wreg), 32'd0);
    check({tag, ".mis"},  32'(out_misalign), 32'd0);
  endtask

  initial begin
    // wb mem alu zero regB wreg pcJump | stall pcsrc | wb alu wreg rd mis
    vecs.push_back('{2'b10, 3'b000, 32'h1234, 1'b0, 32'h0, 5'd7, 32'h0,   1'b0, 1'b0, 2'b10, 32'h1234, 5'd7, 32'h0, 1'b0});
    vecs.push_back('{2'b00, 3'b001, 32'h10, 1'b0, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h1234, 5'd7, 32'h0, 1'b0});
    vecs.push_back('{2'b00, 3'b001, 32'h10, 1'b0, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h10, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h10, 1'b0, 32'h0, 5'd3, 32'h0,   1'b1, 1'b0, 2'b00, 32'h10, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h10, 1'b0, 32'h0, 5'd3, 32'h0,   1'b0, 1'b0, 2'b11, 32'h10, 5'd3, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{2'b00, 3'b100, 32'h0, 1'b1, 32'h0, 5'd0, 32'h40,   1'b0, 1'b1, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{2'b00, 3'b100, 32'h0, 1'b0, 32'h0, 5'd0, 32'h80,   1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{2'b00, 3'b001, 32'h1002, 1'b0, 32'hA5A5, 5'd0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h0, 5'd0, 32'h0, 1'b1});
    vecs.push_back('{2'b00, 3'b001, 32'h1002, 1'b0, 32'hA5A5, 5'd0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h1002, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h0, 1'b0, 32'h0, 5'd4, 32'h0,    1'b1, 1'b0, 2'b00, 32'h1002, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h0, 1'b0, 32'h0, 5'd4, 32'h0,    1'b0, 1'b0, 2'b11, 32'h0, 5'd4, 32'hA5A5, 1'b0});
    vecs.push_back('{2'b00, 3'b011, 32'h8, 1'b0, 32'h5, 5'd0, 32'h0,    1'b1, 1'b0, 2'b00, 32'h0, 5'd4, 32'hA5A5, 1'b0});
    vecs.push_back('{2'b00, 3'b011, 32'h8, 1'b0, 32'h5, 5'd0, 32'h0,    1'b0, 1'b0, 2'b00, 32'h8, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h8, 1'b0, 32'h0, 5'd9, 32'h0,    1'b1, 1'b0, 2'b00, 32'h8, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h8, 1'b0, 32'h0, 5'd9, 32'h0,    1'b0, 1'b0, 2'b11, 32'h8, 5'd9, 32'h5, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h10, 1'b0, 32'h0, 5'd2, 32'h0,   1'b1, 1'b0, 2'b00, 32'h8, 5'd9, 32'h5, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h10, 1'b0, 32'h0, 5'd2, 32'h0,   1'b0, 1'b0, 2'b11, 32'h10, 5'd2, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h20, 1'b0, 32'h0, 5'd5, 32'h0,   1'b1, 1'b0, 2'b00, 32'h10, 5'd2, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{2'b11, 3'b010, 32'h20, 1'b0, 32'h0, 5'd5, 32'h0,   1'b0, 1'b0, 2'b11, 32'h20, 5'd5, 32'h0, 1'b0});

    // Initial reset with an access presented: stall must stay low.
    rst = 1'b0;
    drive(2'b11, 3'b001, 32'h44, 1'b0, 32'h99, 5'd6, 32'h0);
    #2;
    check("rst0.stall", 32'(out_stall), 32'd0);
    tick();
    tick();
    checkAllZero("rst0");
    check("rst0.stall2", 32'(out_stall), 32'd0);
    drive(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
    rst = 1'b1;

    // One table row per clock cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      drive(vecs[i].wb, vecs[i].mem, vecs[i].alu, vecs[i].zero, vecs[i].regB, vecs[i].wreg, vecs[i].pcJump);
      #2;
      check({t, ".stall"},    32'(out_stall), 32'(vecs[i].expStall));
      check({t, ".pcSrc"},    32'(out_pc_src), 32'(vecs[i].expPcSrc));
      check({t, ".pcJump"},   out_pc_jump, vecs[i].pcJump);
      check({t, ".fwdRd"},    32'(fwd_rd), 32'(vecs[i].wreg));
      check({t, ".fwdWr"},    32'(fwd_regF_wr), 32'(vecs[i].wb[1]));
      check({t, ".fwdAlu"},   fwd_alu_result, vecs[i].alu);
      tick();
      check({t, ".wb"},       32'(out_wb), 32'(vecs[i].expWb));
      check({t, ".alu"},      out_alu_result, vecs[i].expAlu);
      check({t, ".wreg"},     32'(out_wreg), 32'(vecs[i].expWreg));
      check({t, ".rd"},       out_read_data, vecs[i].expRd);
      check({t, ".mis"},      32'(out_misalign), 32'(vecs[i].expMis));
    end

    // Reset during WAIT: the pending write to 0x10 must be dropped.
    drive(2'b00, 3'b001, 32'h10, 1'b0, 32'h11111111, 5'd0, 32'h0);
    #2;
    check("rw.stallEnter", 32'(out_stall), 32'd1);
    tick();
    rst = 1'b0;
    #2;
    check("rw.stallForced", 32'(out_stall), 32'd0);
    tick();
    tick();
    checkAllZero("rw");
    rst = 1'b1;
    drive(2'b11, 3'b010, 32'h10, 1'b0, 32'h0, 5'd1, 32'h0);
    #2;
    check("rw.idleAfter", 32'(out_stall), 32'd1);
    tick();
    #2;
    check("rw.stallLast", 32'(out_stall), 32'd0);
    tick();
    check("rw.ramKept", out_read_data, 32'hDEADBEEF);
    check("rw.wreg", 32'(out_wreg), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule
